hazard_controller: RTL and testbench
====================================

// Module: hazard_controller
// PURPOSE
// Pipeline sequencing controller for the uDLX core, between instruction decode (ID) and execute (EX).
// Takes the per-instruction control fields produced by the instruction decoder.
// Tracks destination registers of instructions in flight through EX/MEM/WB.
// Issues load-use stalls, bubble insertion, branch/jump flushes and registered operand forwarding selects.
// PARAMETERS
// REG_ADDR_WIDTH  5  register file address width
// PORTS
// clk              in   1  core clock, all state on rising edge
// rst_n            in   1  asynchronous active-low reset
// id_valid_in      in   1  ID stage holds a real instruction (0 = bubble/NOP)
// rd_addr1_in      in   5  source register 1 address from decoder
// rd_en1_in        in   1  source 1 read enable
// rd_addr2_in      in   5  source register 2 address from decoder
// rd_en2_in        in   1  source 2 read enable
// wr_addr_in       in   5  destination register address from decoder
// wr_en_in         in   1  destination write enable
// mem_rd_en_in     in   1  ID instruction is a load (LW)
// branch_taken_in  in   1  branch/jump in EX resolved taken this cycle
// mem_busy_in      in   1  data memory not ready; freeze whole pipeline
// pc_stall_out     out  1  hold PC
// id_stall_out     out  1  hold IF/ID register
// ex_bubble_out    out  1  load NOP into ID/EX register instead of ID instruction
// flush_out        out  1  squash IF/ID and ID/EX contents (taken branch/jump)
// fwd_a_sel_out    out  2  EX operand A source: 00 regfile, 01 EX/MEM result, 10 MEM/WB result
// fwd_b_sel_out    out  2  EX operand B source, same encoding
// state_out        out  2  FSM state (debug): 00 RUN, 01 LOAD_STALL, 10 FLUSH
// BEHAVIOUR
// - Reset (rst_n=0, async): state=RUN, all shadow regs cleared (wr_en=0), all outputs 0.
// - Shadow pipe: EX{addr,wr_en,load} <- ID fields on advance; MEM <- EX; WB dropped after MEM.
// - Advance: EX loaded with zeros on bubble/flush or id_valid_in=0.
// - Register 0 never produces a hazard or forward (address 0 compare = no match).
// - Match(src,stage): src_en & src_addr!=0 & stage.wr_en & src_addr==stage.addr.
// - Load-use: EX.load & (Match(src1,EX)|Match(src2,EX)) with id_valid_in=1.
// - Priority per cycle: mem_busy_in > branch_taken_in > load-use > advance.
// - mem_busy_in=1: pc_stall/id_stall=1, bubble=0, flush=0; shadows, fwd regs and state hold.
// - RUN: branch_taken_in -> flush_out=1 (same cycle, combinational), EX<-zeros, go FLUSH.
// - RUN: load-use -> pc_stall/id_stall/ex_bubble=1 (combinational), EX<-zeros, go LOAD_STALL.
// - RUN: otherwise -> advance.
// - LOAD_STALL: one cycle; load now in MEM; re-evaluate hazards normally (no double stall); go RUN/FLUSH/LOAD_STALL per rules.
// - FLUSH: one cycle; flush_out=1 again to squash the second wrong-path fetch; EX<-zeros; go RUN.
// - branch_taken_in during FLUSH ignored (wrong-path instr never reaches EX).
// - Forward selects: computed from ID fields vs EX/MEM shadows, registered on advance, so valid the cycle the instruction is in EX (latency 1).
// - Forward select rule: Match vs EX -> 01 (newest wins), else Match vs MEM -> 10, else 00. Forced 00 when bubble/flush loads EX.
// - Reset mid-stall/flush: returns to RUN immediately, all outputs 0.
// - No combinational path from mem_busy_in to forward selects.
// TESTING
// - Reset: assert rst_n=0 mid-FLUSH -> state_out=00, all outputs 0 asynchronously.
// - ADD r3 then ADD r4,r3,r1 -> fwd_a_sel_out=01 in EX; with one NOP between -> 10; no stall.
// - Load-use: LW r5 then ADD r6,r5,r2 -> one cycle pc/id_stall=1, ex_bubble=1, then fwd_a_sel_out=10.
// - LW r0 then read r0 -> no stall, fwd=00; LW r5 then SW (rd_en2, addr 5) -> stall on operand B.
// - branch_taken_in=1 in RUN -> flush_out=1 for 2 consecutive cycles, state 00->10->00.
// - branch_taken_in coincident with load-use -> flush wins, no stall.
// - mem_busy_in held 3 cycles during LOAD_STALL -> stalls held, state stays 01, then resumes exactly as unfrozen.

Source files
------------

// File: rtl/hazard_controller.sv
// Hazard and sequencing controller between ID and EX of the uDLX pipeline.
// Tracks in-flight destinations, raises load-use stalls and branch flushes, and registers forwarding selects.
module hazard_controller #(
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      id_valid_in,
  input  logic [REG_ADDR_WIDTH-1:0] rd_addr1_in,
  input  logic                      rd_en1_in,
  input  logic [REG_ADDR_WIDTH-1:0] rd_addr2_in,
  input  logic                      rd_en2_in,
  input  logic [REG_ADDR_WIDTH-1:0] wr_addr_in,
  input  logic                      wr_en_in,
  input  logic                      mem_rd_en_in,
  input  logic                      branch_taken_in,
  input  logic                      mem_busy_in,
  output logic                      pc_stall_out,
  output logic                      id_stall_out,
  output logic                      ex_bubble_out,
  output logic                      flush_out,
  output logic [1:0]                fwd_a_sel_out,
  output logic [1:0]                fwd_b_sel_out,
  output logic [1:0]                state_out
);

  localparam logic [1:0] ST_RUN        = 2'b00;
  localparam logic [1:0] ST_LOAD_STALL = 2'b01;
  localparam logic [1:0] ST_FLUSH      = 2'b10;

  localparam logic [1:0] FWD_REGFILE = 2'b00;
  localparam logic [1:0] FWD_EX_MEM  = 2'b01;
  localparam logic [1:0] FWD_MEM_WB  = 2'b10;

  logic [1:0]                state_reg, state_next;
  logic [REG_ADDR_WIDTH-1:0] ex_addr_reg, mem_addr_reg;
  logic                      ex_wr_en_reg, ex_load_reg, mem_wr_en_reg;
  logic [1:0]                fwd_a_reg, fwd_b_reg;

  logic [REG_ADDR_WIDTH-1:0] src_addr [2];
  logic [1:0]                src_en;
  logic [1:0]                match_ex, match_mem;
  logic [1:0]                fwd_sel [2];

  assign src_addr[0] = rd_addr1_in;
  assign src_addr[1] = rd_addr2_in;
  assign src_en      = {rd_en2_in, rd_en1_in};

  // Register 0 is hardwired, so it never matches an in-flight writer.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_src
      assign match_ex[gi]  = src_en[gi] && (src_addr[gi] != '0) && ex_wr_en_reg
                             && (src_addr[gi] == ex_addr_reg);
      assign match_mem[gi] = src_en[gi] && (src_addr[gi] != '0) && mem_wr_en_reg
                             && (src_addr[gi] == mem_addr_reg);
      assign fwd_sel[gi]   = match_ex[gi]  ? FWD_EX_MEM :
                             match_mem[gi] ? FWD_MEM_WB : FWD_REGFILE;
    end
  endgenerate

  logic load_use;
  assign load_use = id_valid_in && ex_load_reg && (|match_ex);

  logic stall_c, bubble_c, flush_c, shift_c, advance_c;

  always_comb begin
    stall_c    = 1'b0;
    bubble_c   = 1'b0;
    flush_c    = 1'b0;
    shift_c    = 1'b0;
    advance_c  = 1'b0;
    state_next = state_reg;
    if (mem_busy_in) begin
      stall_c = 1'b1;
    end else if (state_reg == ST_FLUSH) begin
      // Second wrong-path fetch; a branch signal here comes from squashed code.
      flush_c    = 1'b1;
      shift_c    = 1'b1;
      state_next = ST_RUN;
    end else if (branch_taken_in) begin
      flush_c    = 1'b1;
      shift_c    = 1'b1;
      state_next = ST_FLUSH;
    end else if (load_use) begin
      stall_c    = 1'b1;
      bubble_c   = 1'b1;
      shift_c    = 1'b1;
      state_next = ST_LOAD_STALL;
    end else begin
      shift_c    = 1'b1;
      advance_c  = 1'b1;
      state_next = ST_RUN;
    end
  end

  logic take_id;
  assign take_id = advance_c && id_valid_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_RUN;
      ex_addr_reg   <= '0;
      ex_wr_en_reg  <= 1'b0;
      ex_load_reg   <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wr_en_reg <= 1'b0;
      fwd_a_reg     <= FWD_REGFILE;
      fwd_b_reg     <= FWD_REGFILE;
    end else begin
      state_reg <= state_next;
      if (shift_c) begin
        mem_addr_reg  <= ex_addr_reg;
        mem_wr_en_reg <= ex_wr_en_reg;
        ex_addr_reg   <= take_id ? wr_addr_in : '0;
        ex_wr_en_reg  <= take_id && wr_en_in;
        ex_load_reg   <= take_id && mem_rd_en_in;
        fwd_a_reg     <= take_id ? fwd_sel[0] : FWD_REGFILE;
        fwd_b_reg     <= take_id ? fwd_sel[1] : FWD_REGFILE;
      end
    end
  end

  // Gating with rst_n keeps the combinational controls quiet the moment reset asserts.
  assign pc_stall_out  = rst_n && stall_c;
  assign id_stall_out  = rst_n && stall_c;
  assign ex_bubble_out = rst_n && bubble_c;
  assign flush_out     = rst_n && flush_c;
  assign fwd_a_sel_out = fwd_a_reg;
  assign fwd_b_sel_out = fwd_b_reg;
  assign state_out     = state_reg;

endmodule

// File: tb/tb_hazard_controller.sv
// Directed-vector bench for hazard_controller: driver queues hand-computed expectations,
// a negedge monitor pops and compares them against the DUT each cycle.
module tb_hazard_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid_in;
  logic [4:0] rd_addr1_in, rd_addr2_in, wr_addr_in;
  logic       rd_en1_in, rd_en2_in, wr_en_in, mem_rd_en_in;
  logic       branch_taken_in, mem_busy_in;
  logic       pc_stall_out, id_stall_out, ex_bubble_out, flush_out;
  logic [1:0] fwd_a_sel_out, fwd_b_sel_out, state_out;

  always #5 clk = ~clk;

  hazard_controller #(.REG_ADDR_WIDTH(5)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid_in(id_valid_in),
    .rd_addr1_in(rd_addr1_in), .rd_en1_in(rd_en1_in),
    .rd_addr2_in(rd_addr2_in), .rd_en2_in(rd_en2_in),
    .wr_addr_in(wr_addr_in), .wr_en_in(wr_en_in), .mem_rd_en_in(mem_rd_en_in),
    .branch_taken_in(branch_taken_in), .mem_busy_in(mem_busy_in),
    .pc_stall_out(pc_stall_out), .id_stall_out(id_stall_out),
    .ex_bubble_out(ex_bubble_out), .flush_out(flush_out),
    .fwd_a_sel_out(fwd_a_sel_out), .fwd_b_sel_out(fwd_b_sel_out),
    .state_out(state_out)
  );

  typedef struct {
    string      name;
    logic [9:0] exp;
  } sb_entry_t;

  sb_entry_t sb_q[$];
  int        n_vec = 0;
  int        n_bad = 0;

  // {pc_stall, id_stall, bubble, flush, fwd_a, fwd_b, state}
  function automatic logic [9:0] xp(input logic s, input logic b, input logic f,
                                     input logic [1:0] fa, input logic [1:0] fb,
                                     input logic [1:0] st);
    return {s, s, b, f, fa, fb, st};
  endfunction

  task automatic vec(input string nm, input logic r, input logic v,
                     input logic [4:0] a1, input logic e1,
                     input logic [4:0] a2, input logic e2,
                     input logic [4:0] wa, input logic we, input logic ld,
                     input logic br, input logic bz, input logic [9:0] ex);
    sb_entry_t e;
    @(posedge clk);
    #1;
    rst_n = r; id_valid_in = v;
    rd_addr1_in = a1; rd_en1_in = e1; rd_addr2_in = a2; rd_en2_in = e2;
    wr_addr_in = wa; wr_en_in = we; mem_rd_en_in = ld;
    branch_taken_in = br; mem_busy_in = bz;
    e.name = nm;
    e.exp  = ex;
    sb_q.push_back(e);
  endtask

  task automatic nop(input string nm, input logic bz, input logic [9:0] ex);
    vec(nm, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, bz, ex);
  endtask

  initial begin : monitor
    sb_entry_t  e;
    logic [9:0] act;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e   = sb_q.pop_front();
        act = {pc_stall_out, id_stall_out, ex_bubble_out, flush_out,
               fwd_a_sel_out, fwd_b_sel_out, state_out};
        n_vec++;
        if (act !== e.exp) begin
          n_bad++;
          $display("FAIL %s: got pc/id/bub/fl=%b%b%b%b fa=%b fb=%b st=%b, want pc/id/bub/fl=%b%b%b%b fa=%b fb=%b st=%b",
                   e.name, act[9], act[8], act[7], act[6], act[5:4], act[3:2], act[1:0],
                   e.exp[9], e.exp[8], e.exp[7], e.exp[6], e.exp[5:4], e.exp[3:2], e.exp[1:0]);
        end else begin
          $display("ok   %s: pc/id/bub/fl=%b%b%b%b fa=%b fb=%b st=%b",
                   e.name, act[9], act[8], act[7], act[6], act[5:4], act[3:2], act[1:0]);
        end
      end
    end
  end

  initial begin : driver
    rst_n = 1'b0; id_valid_in = 1'b0;
    rd_addr1_in = '0; rd_en1_in = 1'b0; rd_addr2_in = '0; rd_en2_in = 1'b0;
    wr_addr_in = '0; wr_en_in = 1'b0; mem_rd_en_in = 1'b0;
    branch_taken_in = 1'b0; mem_busy_in = 1'b0;
    repeat (2) @(posedge clk);

    vec("reset_hold", 1'b0, 1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1, xp(0,0,0,2'b00,2'b00,2'b00));
    nop("idle", 1'b0, xp(0,0,0,2'b00,2'b00,2'b00));

    // Back-to-back dependency: forward from EX/MEM
    vec("add_r3",     1'b1, 1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, xp(0,0,0,2'b00,2'b00,2'b00));
    vec("add_r4_r3",  1'b1, 1'b1, 5'd3, 1'b1, 5'd1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, xp(0,0,0,2'b00,2'b00,2'b00));
    nop("fwd_ex",     1'b0, xp(0,0,0,2'b01,2'b00,2'b00));

    // One NOP gap: forward from MEM/WB
    vec("add_r7",     1'b1, 1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, xp(0,0,0,2'b00,2'b00,2'b00));
    nop("gap",        1'b0, xp(0,0,0,2'b00,2'b00,2'b00));
    vec("add_r8_r7",  1'b1, 1'b1, 5'd7, 1'b1, 5'd1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, xp(0,0,0,2'b00,2'b00,2'b00));
    nop("fwd_mem",    1'b0, xp(0,0,0,2'b10,2'b00,2'b00));

    // Same destination in EX and MEM: newest (EX) wins, on operand B
    vec("add_r9a",    1'b1, 1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, xp(0,0,0,2'b00,2'b00,2'b00));
    vec("add_r9b",    1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, xp(0,0,0,2'b00,2'b00,2'b00));
    vec("add_x_r9",   1'b1, 1'b1, 5'd2, 1'b1, 5'd9, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0, xp(0,0,0,2'b00,2'b00,2'b00));
    nop("fwd_newest", 1'b0, xp(0,0,0,2'b00,2'b01,2'b00));

    // Load-use on operand A
    vec("lw_r5",      1'b1, 1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, xp(0,0,0,2'b00,2'b00,2'b00));
    vec("lu_stall",   1'b1, 1'b1, 5'd5, 1'b1, 5'd2, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, xp(1,1,0,2'b00,2'b00,2'b00));
    vec("lu_reissue", 1'b1, 1'b1, 5'd5, 1'b1, 5'd2, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, xp(0,0,0,2'b00,2'b00,2'b01));
    nop("lu_fwd_mem", 1'b0, xp(0,0,0,2'b10,2'b00,2'b00));

    // LW r0 then read r0: no stall, no forward
    vec("lw_r0",      1'b1, 1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, xp(0,0,0,2'b00,2'b00,2'b00));
    vec("read_r0",    1'b1, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd11, 1'b1, 1'b0, 1'b0, 1'b0, xp(0,0,0,2'b00,2'b00,2'b00));
    nop("r0_no_fwd",  1'b0, xp(0,0,0,2'b00,2'b00,2'b00));

    // Load-use on operand B (store data)
    vec("lw_r5b",     1'b1, 1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, xp(0,0,0,2'b00,2'b00,2'b00));
    vec("sw_stall",   1'b1, 1'b1, 5'd1, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, xp(1,1,0,2'b00,2'b00,2'b00));
    vec("sw_reissue", 1'b1, 1'b1, 5'd1, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, xp(0,0,0,2'b00,2'b00,2'b01));
    nop("sw_fwd_b",   1'b0, xp(0,0,0,2'b00,2'b10,2'b00));

    // Taken branch: two flush cycles
    vec("br_take",    1'b1, 1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd12, 1'b1, 1'b0, 1'b1, 1'b0, xp(0,0,1,2'b00,2'b00,2'b00));
    vec("br_flush2",  1'b1, 1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd13, 1'b1, 1'b0, 1'b0, 1'b0, xp(0,0,1,2'b00,2'b00,2'b10));
    nop("br_done",    1'b0, xp(0,0,0,2'b00,2'b00,2'b00));

    // Branch asserted again during FLUSH is ignored
    vec("br2_take",   1'b1, 1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd12, 1'b1, 1'b0, 1'b1, 1'b0, xp(0,0,1,2'b00,2'b00,2'b00));
    vec("br2_ignore", 1'b1, 1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd13, 1'b1, 1'b0, 1'b1, 1'b0, xp(0,0,1,2'b00,2'b00,2'b10));
    nop("br2_done",   1'b0, xp(0,0,0,2'b00,2'b00,2'b00));

    // Branch coincident with load-use: flush wins
    vec("lw_r5c",     1'b1, 1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, xp(0,0,0,2'b00,2'b00,2'b00));
    vec("br_vs_lu",   1'b1, 1'b1, 5'd5, 1'b1, 5'd2, 1'b1, 5'd6, 1'b1, 1'b0, 1'b1, 1'b0, xp(0,0,1,2'b00,2'b00,2'b00));
    vec("br_vs_lu2",  1'b1, 1'b1, 5'd5, 1'b1, 5'd2, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, xp(0,0,1,2'b00,2'b00,2'b10));
    nop("br_vs_done", 1'b0, xp(0,0,0,2'b00,2'b00,2'b00));

    // mem_busy for 3 cycles during LOAD_STALL
    vec("lw_r5d",     1'b1, 1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, xp(0,0,0,2'b00,2'b00,2'b00));
    vec("bz_lu",      1'b1, 1'b1, 5'd5, 1'b1, 5'd2, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, xp(1,1,0,2'b00,2'b00,2'b00));
    for (int i = 0; i < 3; i++)
      vec($sformatf("bz_hold%0d", i), 1'b1, 1'b1, 5'd5, 1'b1, 5'd2, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b1,
          xp(1,0,0,2'b00,2'b00,2'b01));
    vec("bz_resume",  1'b1, 1'b1, 5'd5, 1'b1, 5'd2, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, xp(0,0,0,2'b00,2'b00,2'b01));
    nop("bz_fwd_hold", 1'b1, xp(1,0,0,2'b10,2'b00,2'b00));
    nop("bz_fwd_kept", 1'b0, xp(0,0,0,2'b10,2'b00,2'b00));
    nop("bz_clear",    1'b0, xp(0,0,0,2'b00,2'b00,2'b00));

    // Asynchronous reset in the middle of FLUSH
    vec("rst_br",     1'b1, 1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd12, 1'b1, 1'b0, 1'b1, 1'b0, xp(0,0,1,2'b00,2'b00,2'b00));
    vec("rst_mid_fl", 1'b0, 1'b1, 5'd5, 1'b1, 5'd2, 1'b1, 5'd6, 1'b1, 1'b0, 1'b1, 1'b1, xp(0,0,0,2'b00,2'b00,2'b00));
    nop("rst_after",  1'b0, xp(0,0,0,2'b00,2'b00,2'b00));

    repeat (3) @(posedge clk);
    if (sb_q.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain: %0d entries left, want 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
